// File: rtl/fwd_pkg.sv
// -----------------------------------------------------------------------------
// fwd_pkg
// Shared definitions for the EX-stage forwarding / hazard unit.
//   - forwarding select encoding, expressed as functions of the number of
//     downstream stages so every instance agrees on the code layout:
//        0              : register file
//        1 .. NUM_STG   : ALU result of stage k (1 = youngest)
//        NUM_STG + 1    : load data of the last stage (WB)
//        NUM_STG + 2    : long-op (mul/div) result
//   - select width calculation
// -----------------------------------------------------------------------------
package fwd_pkg;

    localparam int FWD_RF = 0;

    function automatic int fwd_load(input int num_stg);
        return num_stg + 1;
    endfunction

    function automatic int fwd_long(input int num_stg);
        return num_stg + 2;
    endfunction

    function automatic int fwd_sel_w(input int num_stg);
        return $clog2(num_stg + 3);
    endfunction

endpackage

// File: rtl/long_scoreboard.sv
// -----------------------------------------------------------------------------
// long_scoreboard
// Tracks the single fixed-latency long op (mul/div) in flight: busy flag,
// destination register, countdown, and the registered write-back strobe
// issued on the cycle after the result becomes valid.
//
// Ports:
//   clk, rst_n      clock / asynchronous active-low reset
//   issue           accept a new long op this cycle (already stall-qualified)
//   issue_addr      destination register of the op being issued
//   busy            long op in flight
//   ready           busy and countdown at zero: result valid this cycle
//   long_addr       destination of the op in flight
//   wb_en           write long result to the register file this cycle
//   wb_addr         destination for wb_en
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no long op in flight
// BUSY  | long op in flight; cnt counts down to 0 (result valid at 0)
// -----------------------------------------------------------------------------
module long_scoreboard #(
    parameter int REG_AW   = 5,
    parameter int LONG_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue,
    input  logic [REG_AW-1:0] issue_addr,
    output logic              busy,
    output logic              ready,
    output logic [REG_AW-1:0] long_addr,
    output logic              wb_en,
    output logic [REG_AW-1:0] wb_addr
);

    localparam int CNT_W = $clog2(LONG_LAT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LONG_LAT - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;

    assign busy  = (state == ST_BUSY);
    assign ready = busy && (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            long_addr <= '0;
            wb_en     <= 1'b0;
            wb_addr   <= '0;
        end else begin
            wb_en <= 1'b0;
            if (state == ST_IDLE) begin
                if (issue) begin
                    state     <= ST_BUSY;
                    cnt       <= CNT_LOAD;
                    long_addr <= issue_addr;
                end
            end else begin
                // Countdown runs regardless of pipeline stall.
                if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end else begin
                    wb_en   <= 1'b1;
                    wb_addr <= long_addr;
                    // A new op may issue on the result cycle (back-to-back);
                    // wb_addr already captured the retiring destination.
                    if (issue) begin
                        cnt       <= CNT_LOAD;
                        long_addr <= issue_addr;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit
// Operand forwarding and hazard detection for NUM_SRC EX-stage sources
// against NUM_STG downstream stages and one fixed-latency long-op unit.
//
// Ports:
//   clk, rst_n      clock / asynchronous active-low reset
//   ex_src_addr     EX source register addresses, source i at [i*REG_AW +: REG_AW]
//   ex_src_used     source i actually read by the EX instruction
//   ex_dst_addr     EX destination register
//   ex_reg_write    EX instruction writes a register
//   ex_long         EX instruction is a long op
//   stg_reg_write   stage k writes a register (bit k-1, stage 1 = youngest)
//   stg_mem_read    stage k holds a load
//   stg_wr_addr     stage k destination at [(k-1)*REG_AW +: REG_AW]
//   fwd_sel         per-source select, source i at [i*SEL_W +: SEL_W]
//   stall           hold IF/ID/EX, bubble into stage 1
//   long_busy       long op in flight
//   long_wb_en      write long result to register file this cycle
//   long_wb_addr    destination for long_wb_en
// -----------------------------------------------------------------------------
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 3,
    parameter int NUM_STG  = 2,
    parameter int LONG_LAT = 4,
    parameter int SEL_W    = fwd_sel_w(NUM_STG)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_SRC*REG_AW-1:0]  ex_src_addr,
    input  logic [NUM_SRC-1:0]         ex_src_used,
    input  logic [REG_AW-1:0]          ex_dst_addr,
    input  logic                       ex_reg_write,
    input  logic                       ex_long,
    input  logic [NUM_STG-1:0]         stg_reg_write,
    input  logic [NUM_STG-1:0]         stg_mem_read,
    input  logic [NUM_STG*REG_AW-1:0]  stg_wr_addr,
    output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
    output logic                       stall,
    output logic                       long_busy,
    output logic                       long_wb_en,
    output logic [REG_AW-1:0]          long_wb_addr
);

    localparam logic [SEL_W-1:0] SEL_RF   = SEL_W'(FWD_RF);
    localparam logic [SEL_W-1:0] SEL_LOAD = SEL_W'(fwd_load(NUM_STG));
    localparam logic [SEL_W-1:0] SEL_LONG = SEL_W'(fwd_long(NUM_STG));

    logic                long_ready;
    logic [REG_AW-1:0]   long_addr;
    logic [NUM_SRC-1:0]  src_stall;
    logic                struct_stall;
    logic                waw_stall;
    logic                issue;

    // Per-source priority scan, youngest stage first.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [REG_AW-1:0] addr;
        logic [SEL_W-1:0]  sel;
        logic              hit;
        logic              src_stl;

        assign addr = ex_src_addr[i*REG_AW +: REG_AW];

        always_comb begin
            sel     = SEL_RF;
            src_stl = 1'b0;
            hit     = 1'b0;
            if (ex_src_used[i] && (addr != '0)) begin
                for (int k = 1; k <= NUM_STG; k++) begin
                    if (!hit && stg_reg_write[k-1] &&
                        (stg_wr_addr[(k-1)*REG_AW +: REG_AW] == addr)) begin
                        hit = 1'b1;
                        if (stg_mem_read[k-1]) begin
                            // Load data only exists once the load reaches WB.
                            if (k < NUM_STG) begin
                                src_stl = 1'b1;
                            end else begin
                                sel = SEL_LOAD;
                            end
                        end else begin
                            sel = SEL_W'(k);
                        end
                    end
                end
                // A younger pipeline writer shadows the long op's result.
                if (!hit && long_busy && (addr == long_addr)) begin
                    if (long_ready) begin
                        sel = SEL_LONG;
                    end else begin
                        src_stl = 1'b1;
                    end
                end
            end
        end

        assign fwd_sel[i*SEL_W +: SEL_W] = sel;
        assign src_stall[i]              = src_stl;
    end

    // Only one long op may be in flight; a new one may enter on the result cycle.
    assign struct_stall = ex_long && long_busy && !long_ready;
    // Keep a short op from writing the long op's destination before it retires.
    assign waw_stall    = ex_reg_write && long_busy && !long_ready &&
                          (ex_dst_addr == long_addr);

    assign stall = (|src_stall) || struct_stall || waw_stall;
    assign issue = ex_long && ex_reg_write && (ex_dst_addr != '0) && !stall;

    long_scoreboard #(
        .REG_AW   (REG_AW),
        .LONG_LAT (LONG_LAT)
    ) u_long_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue      (issue),
        .issue_addr (ex_dst_addr),
        .busy       (long_busy),
        .ready      (long_ready),
        .long_addr  (long_addr),
        .wb_en      (long_wb_en),
        .wb_addr    (long_wb_addr)
    );

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

    localparam int REG_AW   = 5;
    localparam int NUM_SRC  = 3;
    localparam int NUM_STG  = 2;
    localparam int LONG_LAT = 4;
    localparam int SEL_W    = $clog2(NUM_STG + 3);

    logic                      clk;
    logic                      rst_n;
    logic [NUM_SRC*REG_AW-1:0] ex_src_addr;
    logic [NUM_SRC-1:0]        ex_src_used;
    logic [REG_AW-1:0]         ex_dst_addr;
    logic                      ex_reg_write;
    logic                      ex_long;
    logic [NUM_STG-1:0]        stg_reg_write;
    logic [NUM_STG-1:0]        stg_mem_read;
    logic [NUM_STG*REG_AW-1:0] stg_wr_addr;
    logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
    logic                      stall;
    logic                      long_busy;
    logic                      long_wb_en;
    logic [REG_AW-1:0]         long_wb_addr;

    fwd_hazard_unit #(
        .REG_AW   (REG_AW),
        .NUM_SRC  (NUM_SRC),
        .NUM_STG  (NUM_STG),
        .LONG_LAT (LONG_LAT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_src_addr   (ex_src_addr),
        .ex_src_used   (ex_src_used),
        .ex_dst_addr   (ex_dst_addr),
        .ex_reg_write  (ex_reg_write),
        .ex_long       (ex_long),
        .stg_reg_write (stg_reg_write),
        .stg_mem_read  (stg_mem_read),
        .stg_wr_addr   (stg_wr_addr),
        .fwd_sel       (fwd_sel),
        .stall         (stall),
        .long_busy     (long_busy),
        .long_wb_en    (long_wb_en),
        .long_wb_addr  (long_wb_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int dut_sel(input int i);
        return int'(fwd_sel[i*SEL_W +: SEL_W]);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_src_addr   = '0;
        ex_src_used   = '0;
        ex_dst_addr   = '0;
        ex_reg_write  = 1'b0;
        ex_long       = 1'b0;
        stg_reg_write = '0;
        stg_mem_read  = '0;
        stg_wr_addr   = '0;
    endtask

    task automatic set_src(input int i, input int a, input bit used);
        ex_src_addr[i*REG_AW +: REG_AW] = REG_AW'(a);
        ex_src_used[i]                  = used;
    endtask

    task automatic set_stg(input int k, input bit we, input bit ld, input int a);
        stg_reg_write[k-1]                  = we;
        stg_mem_read[k-1]                   = ld;
        stg_wr_addr[(k-1)*REG_AW +: REG_AW] = REG_AW'(a);
    endtask

    task automatic long_issue(input int dst);
        ex_long      = 1'b1;
        ex_reg_write = 1'b1;
        ex_dst_addr  = REG_AW'(dst);
    endtask

    // ---------------- behavioural model ----------------
    // The long op is modelled by timestamps: issued at cycle c, it is busy for
    // cycles c+1 .. c+LONG_LAT, its result is valid at c+LONG_LAT and it is
    // written back at c+LONG_LAT+1.
    int cyc       = 0;
    bit m_valid   = 0;
    int m_addr    = 0;
    int m_done    = 0;
    int m_wb_cyc  = -1;
    int m_wb_addr = 0;

    task automatic model_src(input int i, input bit busy, input bit ready,
                             output int sel, output bit st);
        int a;
        sel = 0;
        st  = 0;
        a   = int'(ex_src_addr[i*REG_AW +: REG_AW]);
        if (!ex_src_used[i] || a == 0) return;
        for (int k = 1; k <= NUM_STG; k++) begin
            if (stg_reg_write[k-1] && int'(stg_wr_addr[(k-1)*REG_AW +: REG_AW]) == a) begin
                if (stg_mem_read[k-1]) begin
                    if (k == NUM_STG) sel = NUM_STG + 1;
                    else              st  = 1;
                end else begin
                    sel = k;
                end
                return;
            end
        end
        if (busy && a == m_addr) begin
            if (ready) sel = NUM_STG + 2;
            else       st  = 1;
        end
    endtask

    initial forever begin
        bit busy, ready, exp_stall, st;
        int s;
        @(negedge clk);
        if (!rst_n) begin
            m_valid   = 0;
            m_wb_cyc  = -1;
            m_wb_addr = 0;
        end
        busy      = m_valid && (cyc <= m_done);
        ready     = busy && (cyc == m_done);
        exp_stall = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            model_src(i, busy, ready, s, st);
            chk($sformatf("model_sel%0d c%0d", i, cyc), dut_sel(i), s);
            exp_stall = exp_stall | st;
        end
        if (busy && !ready && ex_long) exp_stall = 1;
        if (busy && !ready && ex_reg_write && int'(ex_dst_addr) == m_addr) exp_stall = 1;
        chk($sformatf("model_stall c%0d", cyc), int'(stall), int'(exp_stall));
        chk($sformatf("model_busy c%0d", cyc), int'(long_busy), int'(busy));
        chk($sformatf("model_wb_en c%0d", cyc), int'(long_wb_en), int'(cyc == m_wb_cyc));
        chk($sformatf("model_wb_addr c%0d", cyc), int'(long_wb_addr), m_wb_addr);
        if (rst_n) begin
            if (ready) begin
                m_wb_cyc  = cyc + 1;
                m_wb_addr = m_addr;
            end
            if (ex_long && ex_reg_write && ex_dst_addr != 0 && !exp_stall) begin
                m_valid = 1;
                m_addr  = int'(ex_dst_addr);
                m_done  = cyc + LONG_LAT;
            end
        end
        cyc++;
    end

    // ---------------- directed vectors ----------------
    initial begin
        rst_n = 1'b0;
        idle();
        #2;
        chk("rst_busy", int'(long_busy), 0);
        chk("rst_wb_en", int'(long_wb_en), 0);
        chk("rst_wb_addr", int'(long_wb_addr), 0);
        chk("rst_stall", int'(stall), 0);
        chk("rst_sel", int'(fwd_sel), 0);
        repeat (2) tick();
        rst_n = 1'b1;

        // youngest stage wins
        tick(); idle();
        set_stg(1, 1, 0, 5); set_stg(2, 1, 0, 5); set_src(0, 5, 1); set_src(1, 5, 0);
        #1;
        chk("youngest_sel0", dut_sel(0), 1);
        chk("youngest_sel1", dut_sel(1), 0);
        chk("youngest_stall", int'(stall), 0);

        tick(); idle();
        set_stg(2, 1, 0, 6); set_stg(1, 1, 0, 7); set_src(0, 6, 1); set_src(2, 7, 1);
        #1;
        chk("stg2_alu_sel0", dut_sel(0), 2);
        chk("stg1_alu_sel2", dut_sel(2), 1);

        // load-use
        tick(); idle();
        set_stg(1, 1, 1, 7); set_src(1, 7, 1);
        #1;
        chk("load_use_stall", int'(stall), 1);
        chk("load_use_sel1", dut_sel(1), 0);
        tick(); idle();
        set_stg(2, 1, 1, 7); set_src(1, 7, 1);
        #1;
        chk("load_wb_sel1", dut_sel(1), 3);
        chk("load_wb_stall", int'(stall), 0);

        // long op to r9
        tick(); idle(); long_issue(9);
        #1;
        chk("long_issue_stall", int'(stall), 0);
        for (int c = 0; c < 3; c++) begin
            tick(); idle(); set_src(0, 9, 1);
            #1;
            chk($sformatf("long_wait_stall%0d", c), int'(stall), 1);
            chk($sformatf("long_wait_busy%0d", c), int'(long_busy), 1);
        end
        tick(); idle(); set_src(0, 9, 1);
        #1;
        chk("long_ready_sel0", dut_sel(0), 4);
        chk("long_ready_stall", int'(stall), 0);
        tick(); idle();
        #1;
        chk("long_wb_en", int'(long_wb_en), 1);
        chk("long_wb_addr", int'(long_wb_addr), 9);
        chk("long_idle_busy", int'(long_busy), 0);

        // back-to-back long ops: r11 then r12
        tick(); idle(); long_issue(11);
        tick(); idle();
        tick(); idle();
        tick(); idle(); long_issue(12);
        #1;
        chk("b2b_early_stall", int'(stall), 1);
        tick(); idle(); long_issue(12);
        #1;
        chk("b2b_accept_stall", int'(stall), 0);
        tick(); idle();
        #1;
        chk("b2b_busy", int'(long_busy), 1);
        chk("b2b_wb_en", int'(long_wb_en), 1);
        chk("b2b_wb_addr", int'(long_wb_addr), 11);
        tick(); idle(); ex_reg_write = 1'b1; ex_dst_addr = 5'd12;
        #1;
        chk("waw_stall", int'(stall), 1);
        tick(); idle(); ex_reg_write = 1'b1; ex_dst_addr = 5'd13;
        #1;
        chk("waw_other_stall", int'(stall), 0);
        tick(); idle(); ex_reg_write = 1'b1; ex_dst_addr = 5'd12;
        #1;
        chk("waw_ready_stall", int'(stall), 0);

        // address 0 and unused sources
        tick(); idle();
        set_stg(1, 1, 1, 0); set_stg(2, 1, 0, 0);
        for (int i = 0; i < NUM_SRC; i++) set_src(i, 0, 1);
        #1;
        chk("r0_sel", int'(fwd_sel), 0);
        chk("r0_stall", int'(stall), 0);
        chk("b2b_second_wb_addr", int'(long_wb_addr), 12);
        tick(); idle();
        set_stg(1, 1, 1, 12); set_src(0, 12, 0);
        #1;
        chk("unused_sel0", dut_sel(0), 0);
        chk("unused_stall", int'(stall), 0);

        // reset in the middle of a long op
        tick(); idle(); long_issue(13);
        tick(); idle();
        tick(); idle();
        tick(); idle();
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(long_busy), 0);
        chk("midrst_wb_en", int'(long_wb_en), 0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            #1;
            chk($sformatf("midrst_no_wb%0d", c), int'(long_wb_en), 0);
            chk($sformatf("midrst_idle%0d", c), int'(long_busy), 0);
        end

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
